// File: rtl/alarm_pkg.sv
// Shared constants for the alarm sequencer: state encodings, field widths and
// parameter defaults.
package alarm_pkg;

   localparam int HHMM_W  = 16;
   localparam int TIMER_W = 4;
   localparam int COUNT_W = 4;

   localparam int DEF_SNOOZE_MINUTES   = 9;
   localparam int DEF_MAX_SNOOZES      = 3;
   localparam int DEF_RING_TIMEOUT_MIN = 10;

   localparam logic [2:0] ST_DISABLED = 3'd0;
   localparam logic [2:0] ST_ARMED    = 3'd1;
   localparam logic [2:0] ST_RINGING  = 3'd2;
   localparam logic [2:0] ST_SNOOZE   = 3'd3;

endpackage

// File: rtl/alarm_minute_timer.sv
// 4-bit minute counter: clear, load, and saturating up/down steps gated by the
// one-minute enable. Flags describe where the pending step would land.
module alarm_minute_timer
   import alarm_pkg::*;
#(
   parameter int TC = DEF_RING_TIMEOUT_MIN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_clear,
   input  logic               i_load,
   input  logic [TIMER_W-1:0] i_load_val,
   input  logic               i_en,
   input  logic               i_up,
   input  logic               i_down,
   output logic               o_zero,
   output logic               o_tc
);

   localparam logic [TIMER_W-1:0] TC_M1 = TIMER_W'(TC - 1);
   localparam logic [TIMER_W-1:0] MAX_V = '1;

   logic [TIMER_W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && i_up && (r_count != MAX_V)) begin
         r_count <= r_count + 1'b1;
      end else if (i_en && i_down && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Lookahead flags: a down step now reaches zero / an up step now reaches TC.
   assign o_zero = (r_count <= TIMER_W'(1));
   assign o_tc   = (r_count >= TC_M1);

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/stop sequencer: detects the time match, enforces the snooze
// limit and ring timeout, and drives the 1 Hz gated sound output.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MINUTES   = DEF_SNOOZE_MINUTES,
   parameter int MAX_SNOOZES      = DEF_MAX_SNOOZES,
   parameter int RING_TIMEOUT_MIN = DEF_RING_TIMEOUT_MIN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               one_minute,
   input  logic               one_second,
   input  logic [HHMM_W-1:0]  current_time,
   input  logic [HHMM_W-1:0]  alarm_time,
   input  logic               alarm_enable,
   input  logic               load_alarm,
   input  logic               snooze_btn,
   input  logic               stop_btn,
   output logic               sound_alarm,
   output logic               ringing,
   output logic               snoozing,
   output logic [COUNT_W-1:0] snooze_count,
   output logic               missed_alarm,
   output logic [2:0]         state_out
);

   localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_SNOOZES);
   localparam logic [TIMER_W-1:0] SNZ_VAL = TIMER_W'(SNOOZE_MINUTES);

   logic [2:0]         r_state;
   logic [2:0]         w_state_next;
   logic [COUNT_W-1:0] r_snooze_count;
   logic [COUNT_W-1:0] w_count_next;
   logic               r_match_q;
   logic               r_match_qq;
   logic               r_beep_q;
   logic               w_beep_next;
   logic               r_missed;
   logic               w_missed_next;
   logic               w_trigger;
   logic               w_stop;
   logic               w_tmr_clear;
   logic               w_tmr_load;
   logic               w_tmr_up;
   logic               w_tmr_down;
   logic               w_tmr_zero;
   logic               w_tmr_tc;

   // Edge taken on the registered match so the ring starts two cycles after equality.
   assign w_trigger = r_match_q & ~r_match_qq;
   assign w_stop    = stop_btn | load_alarm;

   always_comb begin
      w_state_next  = r_state;
      w_count_next  = r_snooze_count;
      w_beep_next   = r_beep_q;
      w_missed_next = r_missed;
      w_tmr_clear   = 1'b0;
      w_tmr_load    = 1'b0;
      w_tmr_up      = 1'b0;
      w_tmr_down    = 1'b0;
      if (!alarm_enable) begin
         w_state_next = ST_DISABLED;
         w_count_next = '0;
         w_tmr_clear  = 1'b1;
      end else begin
         case (r_state)
            ST_DISABLED: w_state_next = ST_ARMED;
            ST_ARMED: begin
               if (w_stop) begin
                  w_missed_next = 1'b0;
               end else if (w_trigger) begin
                  w_state_next = ST_RINGING;
                  w_tmr_clear  = 1'b1;
                  w_beep_next  = 1'b1;
                  w_count_next = '0;
               end
            end
            ST_RINGING: begin
               if (one_second) begin
                  w_beep_next = ~r_beep_q;
               end
               if (w_stop) begin
                  w_state_next  = ST_ARMED;
                  w_count_next  = '0;
                  w_missed_next = 1'b0;
               end else if (snooze_btn && (r_snooze_count < MAX_CNT)) begin
                  w_state_next = ST_SNOOZE;
                  w_tmr_load   = 1'b1;
                  w_count_next = r_snooze_count + 1'b1;
               end else if (one_minute) begin
                  w_tmr_up = 1'b1;
                  if (w_tmr_tc) begin
                     w_state_next  = ST_ARMED;
                     w_missed_next = 1'b1;
                     w_count_next  = '0;
                  end
               end
            end
            ST_SNOOZE: begin
               if (w_stop) begin
                  w_state_next = ST_ARMED;
                  w_count_next = '0;
               end else if (one_minute) begin
                  w_tmr_down = 1'b1;
                  if (w_tmr_zero) begin
                     w_state_next = ST_RINGING;
                     w_beep_next  = 1'b1;
                  end
               end
            end
            default: w_state_next = ST_DISABLED;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_DISABLED;
         r_snooze_count <= '0;
         r_match_q      <= 1'b0;
         r_match_qq     <= 1'b0;
         r_beep_q       <= 1'b0;
         r_missed       <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_snooze_count <= w_count_next;
         r_match_q      <= (current_time == alarm_time);
         r_match_qq     <= r_match_q;
         r_beep_q       <= w_beep_next;
         r_missed       <= w_missed_next;
      end
   end

   alarm_minute_timer #(
      .TC(RING_TIMEOUT_MIN)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_tmr_clear),
      .i_load     (w_tmr_load),
      .i_load_val (SNZ_VAL),
      .i_en       (one_minute),
      .i_up       (w_tmr_up),
      .i_down     (w_tmr_down),
      .o_zero     (w_tmr_zero),
      .o_tc       (w_tmr_tc)
   );

   assign sound_alarm  = (r_state == ST_RINGING) & r_beep_q;
   assign ringing      = (r_state == ST_RINGING);
   assign snoozing     = (r_state == ST_SNOOZE);
   assign snooze_count = r_snooze_count;
   assign missed_alarm = r_missed;
   assign state_out    = r_state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios and random pulses checked each
// cycle against an event-rule model of the alarm behaviour.
module tb_alarm_sequencer;

   localparam int SNZ  = 9;
   localparam int MAXS = 3;
   localparam int TO   = 10;

   localparam int S_DIS  = 0;
   localparam int S_ARM  = 1;
   localparam int S_RING = 2;
   localparam int S_SNZ  = 3;

   logic        clk;
   logic        reset;
   logic        one_minute;
   logic        one_second;
   logic [15:0] current_time;
   logic [15:0] alarm_time;
   logic        alarm_enable;
   logic        load_alarm;
   logic        snooze_btn;
   logic        stop_btn;
   logic        sound_alarm;
   logic        ringing;
   logic        snoozing;
   logic [3:0]  snooze_count;
   logic        missed_alarm;
   logic [2:0]  state_out;

   int n_compared;
   int n_mismatched;

   // Model state
   int m_state;
   int m_cnt;
   int m_timer;
   bit m_beep;
   bit m_missed;
   bit m_match_hist [2];

   alarm_sequencer #(
      .SNOOZE_MINUTES   (SNZ),
      .MAX_SNOOZES      (MAXS),
      .RING_TIMEOUT_MIN (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .one_minute   (one_minute),
      .one_second   (one_second),
      .current_time (current_time),
      .alarm_time   (alarm_time),
      .alarm_enable (alarm_enable),
      .load_alarm   (load_alarm),
      .snooze_btn   (snooze_btn),
      .stop_btn     (stop_btn),
      .sound_alarm  (sound_alarm),
      .ringing      (ringing),
      .snoozing     (snoozing),
      .snooze_count (snooze_count),
      .missed_alarm (missed_alarm),
      .state_out    (state_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_compared++;
      if (obs != exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state         = S_DIS;
      m_cnt           = 0;
      m_timer         = 0;
      m_beep          = 1'b0;
      m_missed        = 1'b0;
      m_match_hist[0] = 1'b0;
      m_match_hist[1] = 1'b0;
   endtask

   // One clock of the alarm rules, using the inputs presented in that cycle.
   task automatic model_clock();
      bit trig;
      bit stop;
      if (reset) begin
         model_reset();
         return;
      end
      trig            = m_match_hist[0] && !m_match_hist[1];
      m_match_hist[1] = m_match_hist[0];
      m_match_hist[0] = (current_time == alarm_time);
      stop            = stop_btn || load_alarm;
      if (!alarm_enable) begin
         m_state = S_DIS;
         m_cnt   = 0;
         m_timer = 0;
      end else begin
         case (m_state)
            S_DIS: m_state = S_ARM;
            S_ARM: begin
               if (stop) m_missed = 1'b0;
               else if (trig) begin
                  m_state = S_RING; m_timer = 0; m_beep = 1'b1; m_cnt = 0;
               end
            end
            S_RING: begin
               if (one_second) m_beep = !m_beep;
               if (stop) begin
                  m_state = S_ARM; m_cnt = 0; m_missed = 1'b0;
               end else if (snooze_btn && m_cnt < MAXS) begin
                  m_state = S_SNZ; m_timer = SNZ; m_cnt++;
               end else if (one_minute) begin
                  if (m_timer < 15) m_timer++;
                  if (m_timer >= TO) begin
                     m_state = S_ARM; m_missed = 1'b1; m_cnt = 0;
                  end
               end
            end
            default: begin
               if (stop) begin
                  m_state = S_ARM; m_cnt = 0;
               end else if (one_minute) begin
                  if (m_timer > 0) m_timer--;
                  if (m_timer == 0) begin
                     m_state = S_RING; m_beep = 1'b1;
                  end
               end
            end
         endcase
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "/state"}, int'(state_out), m_state);
      check_eq({tag, "/sound"}, int'(sound_alarm), int'(m_state == S_RING && m_beep));
      check_eq({tag, "/ringing"}, int'(ringing), int'(m_state == S_RING));
      check_eq({tag, "/snoozing"}, int'(snoozing), int'(m_state == S_SNZ));
      check_eq({tag, "/count"}, int'(snooze_count), m_cnt);
      check_eq({tag, "/missed"}, int'(missed_alarm), int'(m_missed));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_clock();
      #1;
      check_outputs(tag);
      one_minute = 1'b0;
      one_second = 1'b0;
      snooze_btn = 1'b0;
      stop_btn   = 1'b0;
      load_alarm = 1'b0;
   endtask

   task automatic ring_now(input string tag);
      current_time = 16'h0659;
      cycle(tag);
      cycle(tag);
      current_time = 16'h0700;
      cycle(tag);
      check_eq({tag, "/not_yet"}, int'(ringing), 0);
      cycle(tag);
      check_eq({tag, "/ring_t2"}, int'(ringing), 1);
   endtask

   task automatic snooze_round(input string tag);
      snooze_btn = 1'b1;
      cycle(tag);
      for (int i = 0; i < SNZ; i++) begin
         one_minute = 1'b1;
         cycle(tag);
      end
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      reset        = 1'b1;
      one_minute   = 1'b0;
      one_second   = 1'b0;
      snooze_btn   = 1'b0;
      stop_btn     = 1'b0;
      load_alarm   = 1'b0;
      alarm_enable = 1'b0;
      alarm_time   = 16'h0700;
      current_time = 16'h0659;
      model_reset();
      #1;
      check_outputs("reset_async");
      cycle("reset");
      cycle("reset");
      reset = 1'b0;
      $display("[tb] reset checked");

      // 1: ring at T+2, 1 Hz beeping, stop
      alarm_enable = 1'b1;
      cycle("t1");
      check_eq("t1_armed", int'(state_out), S_ARM);
      ring_now("t1");
      check_eq("t1_sound_on", int'(sound_alarm), 1);
      one_second = 1'b1;
      cycle("t1");
      check_eq("t1_sound_off", int'(sound_alarm), 0);
      one_second = 1'b1;
      cycle("t1");
      check_eq("t1_sound_back", int'(sound_alarm), 1);
      stop_btn = 1'b1;
      cycle("t1");
      check_eq("t1_stopped", int'(state_out), S_ARM);
      check_eq("t1_silent", int'(sound_alarm), 0);
      $display("[tb] scenario 1 ring/beep/stop done");

      // 2: one full snooze
      ring_now("t2");
      snooze_btn = 1'b1;
      cycle("t2");
      check_eq("t2_snoozing", int'(snoozing), 1);
      for (int i = 1; i <= SNZ; i++) begin
         one_minute = 1'b1;
         cycle("t2");
         check_eq("t2_phase", int'(ringing), int'(i == SNZ));
      end
      check_eq("t2_count", int'(snooze_count), 1);
      $display("[tb] scenario 2 snooze cycle done");

      // 3: snooze limit
      snooze_round("t3");
      snooze_round("t3");
      check_eq("t3_ringing", int'(ringing), 1);
      check_eq("t3_count", int'(snooze_count), MAXS);
      snooze_btn = 1'b1;
      cycle("t3");
      check_eq("t3_ignored", int'(ringing), 1);
      check_eq("t3_count_held", int'(snooze_count), MAXS);
      $display("[tb] scenario 3 snooze limit done");

      // 4: unattended timeout, then load clears missed flag
      stop_btn = 1'b1;
      cycle("t4");
      ring_now("t4");
      for (int i = 1; i <= TO; i++) begin
         one_minute = 1'b1;
         cycle("t4");
         check_eq("t4_ring_phase", int'(ringing), int'(i < TO));
      end
      check_eq("t4_armed", int'(state_out), S_ARM);
      check_eq("t4_missed", int'(missed_alarm), 1);
      load_alarm = 1'b1;
      cycle("t4");
      check_eq("t4_missed_clr", int'(missed_alarm), 0);
      $display("[tb] scenario 4 timeout done");

      // 5: same-cycle events
      ring_now("t5");
      snooze_btn = 1'b1;
      one_minute = 1'b1;
      cycle("t5");
      check_eq("t5_timer", int'(dut.u_timer.r_count), SNZ);
      check_eq("t5_snoozing", int'(snoozing), 1);
      for (int i = 1; i <= SNZ; i++) begin
         one_minute = 1'b1;
         cycle("t5");
      end
      check_eq("t5_reringing", int'(ringing), 1);
      stop_btn   = 1'b1;
      snooze_btn = 1'b1;
      cycle("t5");
      check_eq("t5_stop_wins", int'(state_out), S_ARM);
      check_eq("t5_count0", int'(snooze_count), 0);
      $display("[tb] scenario 5 same-cycle events done");

      // 6: async reset mid-ring, enable drop, held match
      ring_now("t6");
      #2 reset = 1'b1;
      #1;
      check_eq("t6_rst_sound", int'(sound_alarm), 0);
      check_eq("t6_rst_state", int'(state_out), S_DIS);
      model_reset();
      cycle("t6");
      current_time = 16'h0659;
      reset        = 1'b0;
      cycle("t6");
      ring_now("t6");
      alarm_enable = 1'b0;
      cycle("t6");
      check_eq("t6_dis_sound", int'(sound_alarm), 0);
      check_eq("t6_dis_state", int'(state_out), S_DIS);
      alarm_enable = 1'b1;
      for (int i = 0; i < 6; i++) cycle("t6");
      check_eq("t6_no_rering", int'(state_out), S_ARM);
      ring_now("t6");
      stop_btn = 1'b1;
      cycle("t6");
      $display("[tb] scenario 6 reset/disable done");

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 149) == 0) alarm_enable = ~alarm_enable;
         if ($urandom_range(0, 29) == 0)
            current_time = (current_time == 16'h0700) ? 16'h0659 : 16'h0700;
         one_second = ($urandom_range(0, 3) == 0);
         one_minute = ($urandom_range(0, 5) == 0);
         snooze_btn = ($urandom_range(0, 9) == 0);
         stop_btn   = ($urandom_range(0, 79) == 0);
         load_alarm = ($urandom_range(0, 119) == 0);
         cycle("rnd");
      end
      $display("[tb] random traffic done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
